// File: rtl/exec_regfile.sv
// exec_regfile: execute/writeback stage for the decoder's registered outputs.
// Applies ADD/SUB/MUL/CMP in one cycle, or DIV/MOD via an 8-iteration
// restoring divider, to accumulator R0 or R1 and writes the result back.
//
// Ports:
//   clock, reset      - rising-edge clock, asynchronous active-high reset
//   ena               - global enable; all state holds when low
//   alu_opcode        - 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 MOD, 101 CMP, 11x NOP
//   operand           - 4-bit unsigned immediate (zero-extended)
//   reg_sel           - accumulator select (source and destination)
//   alu_enable        - operation request
//   write_enable      - write result back to the selected accumulator
//   busy              - divider running; upstream stalls while high
//   r0, r1            - accumulator contents
//   result            - last completed result
//   valid_out         - one-cycle pulse per completed operation
//   flag_zero         - last result was zero
//   flag_carry        - carry/borrow/overflow of last operation
//   div_by_zero       - last completed operation was DIV/MOD by zero
module exec_regfile #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ena,
    input  logic [2:0]        alu_opcode,
    input  logic [3:0]        operand,
    input  logic              reg_sel,
    input  logic              alu_enable,
    input  logic              write_enable,
    output logic              busy,
    output logic [DATA_W-1:0] r0,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] result,
    output logic              valid_out,
    output logic              flag_zero,
    output logic              flag_carry,
    output logic              div_by_zero
);

    localparam int CW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_DIV  = 3'b011,
        OP_MOD  = 3'b100,
        OP_CMP  = 3'b101,
        OP_NOP0 = 3'b110,
        OP_NOP1 = 3'b111
    } op_e;

    typedef enum logic {
        IDLE   = 1'b0,
        DIVIDE = 1'b1
    } state_e;

    state_e            state;
    op_e               op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0] op_res;
    logic              op_carry;
    logic              op_dbz;
    logic              is_div;
    logic              accept;

    // Divider datapath: quo holds the remaining dividend bits shifting out
    // MSB first while quotient bits shift in from the bottom.
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] divisor;
    logic [CW-1:0]     count;
    logic              div_mod;
    logic              div_sel;
    logic              div_we;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   trial;
    logic              ge;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] quo_next;
    logic [DATA_W-1:0] div_res;

    always_comb begin
        op     = op_e'(alu_opcode);
        a      = reg_sel ? r1 : r0;
        b      = {{(DATA_W-4){1'b0}}, operand};
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        prod   = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        is_div = (op == OP_DIV) || (op == OP_MOD);
        accept = alu_enable && (state == IDLE) && (op != OP_NOP0) && (op != OP_NOP1);
    end

    // Single-cycle results; the DIV/MOD entries only apply to a zero divisor.
    always_comb begin
        op_res   = '0;
        op_carry = 1'b0;
        op_dbz   = 1'b0;
        case (op)
            OP_ADD: begin
                op_res   = sum[DATA_W-1:0];
                op_carry = sum[DATA_W];
            end
            OP_SUB, OP_CMP: begin
                op_res   = diff[DATA_W-1:0];
                op_carry = diff[DATA_W];
            end
            OP_MUL: begin
                op_res   = prod[DATA_W-1:0];
                op_carry = |prod[2*DATA_W-1:DATA_W];
            end
            OP_DIV: begin
                op_res = '1;
                op_dbz = 1'b1;
            end
            OP_MOD: begin
                op_res = a;
                op_dbz = 1'b1;
            end
            default: begin
                op_res   = '0;
                op_carry = 1'b0;
                op_dbz   = 1'b0;
            end
        endcase
    end

    // One restoring-division step.
    always_comb begin
        shifted  = {rem, quo[DATA_W-1]};
        trial    = shifted - {1'b0, divisor};
        ge       = (shifted >= {1'b0, divisor});
        rem_next = ge ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
        quo_next = {quo[DATA_W-2:0], ge};
        div_res  = div_mod ? rem_next : quo_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            r0          <= '0;
            r1          <= '0;
            result      <= '0;
            valid_out   <= 1'b0;
            flag_zero   <= 1'b0;
            flag_carry  <= 1'b0;
            div_by_zero <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            divisor     <= '0;
            count       <= '0;
            div_mod     <= 1'b0;
            div_sel     <= 1'b0;
            div_we      <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (ena) begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            if (is_div && (operand != 4'd0)) begin
                                state   <= DIVIDE;
                                busy    <= 1'b1;
                                rem     <= '0;
                                quo     <= a;
                                divisor <= b;
                                count   <= CW'(DATA_W-1);
                                div_mod <= (op == OP_MOD);
                                div_sel <= reg_sel;
                                div_we  <= write_enable;
                            end else begin
                                result      <= op_res;
                                flag_zero   <= (op_res == '0);
                                flag_carry  <= op_carry;
                                div_by_zero <= op_dbz;
                                valid_out   <= 1'b1;
                                if (write_enable && (op != OP_CMP)) begin
                                    if (reg_sel) r1 <= op_res;
                                    else         r0 <= op_res;
                                end
                            end
                        end
                    end
                    DIVIDE: begin
                        rem   <= rem_next;
                        quo   <= quo_next;
                        count <= count - 1'b1;
                        if (count == '0) begin
                            state       <= IDLE;
                            busy        <= 1'b0;
                            result      <= div_res;
                            flag_zero   <= (div_res == '0);
                            flag_carry  <= 1'b0;
                            div_by_zero <= 1'b0;
                            valid_out   <= 1'b1;
                            if (div_we) begin
                                if (div_sel) r1 <= div_res;
                                else         r0 <= div_res;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_exec_regfile.sv
module tb_exec_regfile;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ena = 1'b0;
    logic [2:0] alu_opcode = 3'b000;
    logic [3:0] operand = 4'd0;
    logic       reg_sel = 1'b0;
    logic       alu_enable = 1'b0;
    logic       write_enable = 1'b0;
    logic       busy;
    logic [7:0] r0;
    logic [7:0] r1;
    logic [7:0] result;
    logic       valid_out;
    logic       flag_zero;
    logic       flag_carry;
    logic       div_by_zero;

    int errors = 0;
    int checks = 0;

    exec_regfile #(.DATA_W(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .ena          (ena),
        .alu_opcode   (alu_opcode),
        .operand      (operand),
        .reg_sel      (reg_sel),
        .alu_enable   (alu_enable),
        .write_enable (write_enable),
        .busy         (busy),
        .r0           (r0),
        .r1           (r1),
        .result       (result),
        .valid_out    (valid_out),
        .flag_zero    (flag_zero),
        .flag_carry   (flag_carry),
        .div_by_zero  (div_by_zero)
    );

    always #5 clock = ~clock;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MUL = 3'b010,
                           DIV = 3'b011, MOD = 3'b100, CMP = 3'b101, NOP = 3'b110;

    typedef struct {
        logic [2:0] op;
        logic [3:0] opnd;
        logic       sel;
        logic       we;
        logic       aen;
        logic       en;
        int         rep;
        logic [7:0] e_r0;
        logic [7:0] e_r1;
        logic [7:0] e_res;
        logic       e_v;
        logic       e_z;
        logic       e_c;
        logic       e_d;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mk(input logic [2:0] op, input logic [3:0] opnd,
                                input logic sel, input logic we, input logic aen,
                                input logic en, input int rep,
                                input logic [7:0] e_r0, input logic [7:0] e_r1,
                                input logic [7:0] e_res, input logic e_v,
                                input logic e_z, input logic e_c, input logic e_d);
        vec_t v;
        v.op = op; v.opnd = opnd; v.sel = sel; v.we = we; v.aen = aen; v.en = en;
        v.rep = rep; v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_res = e_res;
        v.e_v = e_v; v.e_z = e_z; v.e_c = e_c; v.e_d = e_d;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, take the edge, and settle 1 time unit after it.
    task automatic step(input logic [2:0] op, input logic [3:0] opnd, input logic sel,
                        input logic we, input logic aen, input logic en);
        alu_opcode = op; operand = opnd; reg_sel = sel;
        write_enable = we; alu_enable = aen; ena = en;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        step(NOP, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        //            op   opnd  sel we aen en rep  r0     r1     res    v z c d
        tbl[0]  = mk(ADD, 4'd3,  0, 1, 1, 1, 1,  8'h03, 8'h00, 8'h03, 1,0,0,0);
        tbl[1]  = mk(NOP, 4'd3,  0, 1, 1, 1, 1,  8'h03, 8'h00, 8'h03, 0,0,0,0);
        tbl[2]  = mk(SUB, 4'd3,  0, 1, 1, 1, 1,  8'h00, 8'h00, 8'h00, 1,1,0,0);
        tbl[3]  = mk(SUB, 4'd2,  0, 1, 1, 1, 1,  8'hFE, 8'h00, 8'hFE, 1,0,1,0);
        tbl[4]  = mk(ADD, 4'd7,  0, 1, 1, 1, 1,  8'h05, 8'h00, 8'h05, 1,0,1,0);
        tbl[5]  = mk(CMP, 4'd5,  0, 0, 1, 1, 1,  8'h05, 8'h00, 8'h00, 1,1,0,0);
        tbl[6]  = mk(CMP, 4'd5,  0, 1, 1, 1, 1,  8'h05, 8'h00, 8'h00, 1,1,0,0);
        tbl[7]  = mk(ADD, 4'd1,  0, 1, 1, 0, 1,  8'h05, 8'h00, 8'h00, 0,1,0,0);
        tbl[8]  = mk(ADD, 4'd1,  0, 0, 1, 1, 1,  8'h05, 8'h00, 8'h06, 1,0,0,0);
        tbl[9]  = mk(ADD, 4'd15, 1, 1, 1, 1, 17, 8'h05, 8'hFF, 8'hFF, 1,0,0,0);
        tbl[10] = mk(ADD, 4'd1,  1, 1, 1, 1, 1,  8'h05, 8'h00, 8'h00, 1,1,1,0);
        tbl[11] = mk(ADD, 4'd15, 1, 1, 1, 1, 1,  8'h05, 8'h0F, 8'h0F, 1,0,0,0);
        tbl[12] = mk(MUL, 4'd15, 1, 1, 1, 1, 1,  8'h05, 8'hE1, 8'hE1, 1,0,0,0);
        tbl[13] = mk(MUL, 4'd2,  1, 1, 1, 1, 1,  8'h05, 8'hC2, 8'hC2, 1,0,1,0);
        tbl[14] = mk(ADD, 4'd1,  1, 1, 0, 1, 1,  8'h05, 8'hC2, 8'hC2, 0,0,1,0);
        tbl[15] = mk(SUB, 4'd5,  0, 1, 1, 1, 1,  8'h00, 8'hC2, 8'h00, 1,1,0,0);
        tbl[16] = mk(ADD, 4'd15, 0, 1, 1, 1, 1,  8'h0F, 8'hC2, 8'h0F, 1,0,0,0);
        tbl[17] = mk(MUL, 4'd13, 0, 1, 1, 1, 1,  8'hC3, 8'hC2, 8'hC3, 1,0,0,0);
        tbl[18] = mk(MUL, 4'd0,  1, 1, 1, 1, 1,  8'hC3, 8'h00, 8'h00, 1,1,0,0);
        tbl[19] = mk(ADD, 4'd9,  1, 1, 1, 1, 1,  8'hC3, 8'h09, 8'h09, 1,0,0,0);
        tbl[20] = mk(MOD, 4'd0,  1, 1, 1, 1, 1,  8'hC3, 8'h09, 8'h09, 1,0,0,1);
        tbl[21] = mk(DIV, 4'd0,  1, 1, 1, 1, 1,  8'hC3, 8'hFF, 8'hFF, 1,0,0,1);
        tbl[22] = mk(ADD, 4'd1,  1, 1, 1, 1, 1,  8'hC3, 8'h00, 8'h00, 1,1,1,0);

        // Reset state
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("reset r0", r0, 8'h00);
        chk("reset r1", r1, 8'h00);
        chk("reset result", result, 8'h00);
        chk("reset busy", busy, 1'b0);
        chk("reset valid", valid_out, 1'b0);
        chk("reset flags", {flag_zero, flag_carry, div_by_zero}, 3'b000);

        // Table of single-cycle operations
        for (int i = 0; i < 23; i++) begin
            for (int k = 0; k < tbl[i].rep; k++)
                step(tbl[i].op, tbl[i].opnd, tbl[i].sel, tbl[i].we, tbl[i].aen, tbl[i].en);
            chk($sformatf("row%0d r0", i), r0, tbl[i].e_r0);
            chk($sformatf("row%0d r1", i), r1, tbl[i].e_r1);
            chk($sformatf("row%0d result", i), result, tbl[i].e_res);
            chk($sformatf("row%0d valid", i), valid_out, tbl[i].e_v);
            chk($sformatf("row%0d zero", i), flag_zero, tbl[i].e_z);
            chk($sformatf("row%0d carry", i), flag_carry, tbl[i].e_c);
            chk($sformatf("row%0d dbz", i), div_by_zero, tbl[i].e_d);
            chk($sformatf("row%0d busy", i), busy, 1'b0);
        end

        // DIV R0,7 with r0=195; an ADD is presented every busy cycle
        step(DIV, 4'd7, 0, 1, 1, 1);
        chk("div7 busy after accept", busy, 1'b1);
        chk("div7 no early valid", valid_out, 1'b0);
        n = 0;
        while (!valid_out && n < 20) begin
            step(ADD, 4'd1, 0, 1, 1, 1);
            n++;
        end
        chk("div7 latency", n, 8);
        chk("div7 busy cleared", busy, 1'b0);
        chk("div7 r0", r0, 8'd27);
        chk("div7 result", result, 8'd27);
        chk("div7 flags", {flag_zero, flag_carry, div_by_zero}, 3'b000);
        idle();
        chk("div7 valid one cycle", valid_out, 1'b0);
        chk("div7 ignored add", r0, 8'd27);

        // Remainder of R0 by 5 -> 2
        step(MOD, 4'd5, 0, 1, 1, 1);
        n = 0;
        while (!valid_out && n < 20) begin
            idle();
            n++;
        end
        chk("mod5 latency", n, 8);
        chk("mod5 r0", r0, 8'd2);

        // r0 = 100, then DIV R0,3 with ena low for 3 cycles mid-divide
        step(SUB, 4'd2, 0, 1, 1, 1);
        step(ADD, 4'd10, 0, 1, 1, 1);
        step(MUL, 4'd10, 0, 1, 1, 1);
        chk("setup r0=100", r0, 8'd100);
        step(DIV, 4'd3, 0, 1, 1, 1);
        for (int k = 0; k < 3; k++) idle();
        for (int k = 0; k < 3; k++) step(NOP, 4'd0, 0, 0, 0, 0);
        chk("freeze busy held", busy, 1'b1);
        n = 6;
        while (!valid_out && n < 30) begin
            idle();
            n++;
        end
        chk("freeze latency", n, 11);
        chk("freeze r0", r0, 8'd33);

        // DIV R0,3 again, reset asserted during the 4th iteration
        step(DIV, 4'd3, 0, 1, 1, 1);
        for (int k = 0; k < 3; k++) idle();
        chk("pre-reset busy", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort busy", busy, 1'b0);
        chk("abort r0", r0, 8'h00);
        chk("abort result", result, 8'h00);
        chk("abort valid", valid_out, 1'b0);
        chk("abort flags", {flag_zero, flag_carry, div_by_zero}, 3'b000);
        @(posedge clock);
        #1;
        reset = 1'b0;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            idle();
            if (valid_out || busy) n++;
        end
        chk("abort no completion", n, 0);
        step(ADD, 4'd4, 0, 1, 1, 1);
        chk("post-reset add", r0, 8'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
